// File: rtl/gate_share_scheduler.sv
// gate_share_scheduler: shares one external 1-bit AND gate among four
// requesters. A round-robin winner's operands are latched, streamed through
// the gate LSB first, and the collected bits are returned as a WIDTH-bit result.
module gate_share_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_bus,
  input  logic [4*WIDTH-1:0]   b_bus,
  output logic                 a,
  output logic                 b,
  input  logic                 y,
  output logic [3:0]           gnt,
  output logic [3:0]           done,
  output logic [WIDTH-1:0]     result,
  output logic                 busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;

  // Round-robin search: first requester at or after the pointer, wrapping 3->0.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and output logic of the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    a        = 1'b0;
    b        = 1'b0;
    done     = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          ptr_d   = win_idx + 2'd1;
          op_a_d  = a_bus[win_idx*WIDTH +: WIDTH];
          op_b_d  = b_bus[win_idx*WIDTH +: WIDTH];
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a               = op_a_q[idx_q];
        b               = op_b_q[idx_q];
        shadow_d[idx_q] = y;
        if (idx_q == LAST_IDX) begin
          // The last gate bit goes straight into the result on entry to DONE.
          result_d = shadow_d;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = gnt_q;
        gnt_d   = 4'b0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset wins over any request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      shadow_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
    end
  end

  assign gnt    = gnt_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_share_scheduler.sv
// Self-checking bench for gate_share_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_gate_share_scheduler;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] a_bus = '0;
  logic [4*W-1:0] b_bus = '0;
  logic           a, b, y;
  logic [3:0]     gnt, done;
  logic [W-1:0]   result;
  logic           busy;

  int errors = 0;
  int checks = 0;

  gate_share_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .a(a), .b(b), .y(y), .gnt(gnt), .done(done), .result(result), .busy(busy)
  );

  // The shared external AND gate.
  assign y = a & b;

  always #5 clk = ~clk;

  // Reference model: an operation occupies WIDTH+1 cycles after its grant
  // edge (WIDTH shifting cycles, then one done cycle); m_cnt counts the
  // cycles remaining, and the result is simply A & B of the latched operands.
  int         m_cnt = 0;
  int         m_g   = 0;
  int         m_ptr = 0;
  int         mg;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_ptr <= 0;
      m_res <= '0;
    end else if (m_cnt == 0) begin
      if (req != 4'b0000) begin
        mg = -1;
        for (int k = 0; k < 4; k++)
          if (mg < 0 && req[(m_ptr + k) % 4]) mg = (m_ptr + k) % 4;
        m_g   <= mg;
        m_cnt <= W + 1;
        m_ptr <= (mg + 1) % 4;
        m_a   <= a_bus[mg*W +: W];
        m_b   <= b_bus[mg*W +: W];
      end
    end else begin
      if (m_cnt == 2) m_res <= m_a & m_b;
      m_cnt <= m_cnt - 1;
    end
  end

  logic [3:0] e_gnt, e_done;
  logic       e_a, e_b, e_busy;

  always_comb begin
    e_gnt  = '0;
    e_done = '0;
    e_a    = 1'b0;
    e_b    = 1'b0;
    e_busy = (m_cnt > 0);
    if (m_cnt > 0) e_gnt = 4'b0001 << m_g;
    if (m_cnt == 1) e_done = e_gnt;
    if (m_cnt >= 2) begin
      e_a = m_a[W + 1 - m_cnt];
      e_b = m_b[W + 1 - m_cnt];
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (done != 4'b0000) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    a_bus = $urandom();
    b_bus = $urandom();
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if ({a, b} !== 2'b00) begin errors++; $display("FAIL reset_ab: got %b expected 00", {a, b}); end
    rst = 1'b0;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c;
    a_bus[0 +: W] = 8'hF0;
    b_bus[0 +: W] = 8'h3C;
    req = 4'b0001;
    wait_grant(5, c);
    checks++; if (c !== 1) begin errors++; $display("FAIL single_grant_latency: got %0d expected 1", c); end
    req = 4'b0000;
    for (int k = 0; k < W; k++) begin
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_held: got %b expected 0001 at cycle %0d", gnt, k); end
      @(negedge clk);
    end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done); end
    checks++; if (result !== 8'h30) begin errors++; $display("FAIL single_result: got %h expected 30", result); end
    @(negedge clk);
    checks++; if ({gnt, done, busy} !== 9'b0) begin errors++; $display("FAIL single_idle: got gnt=%b done=%b busy=%b expected zeros", gnt, done, busy); end
    checks++; if (result !== 8'h30) begin errors++; $display("FAIL single_result_hold: got %h expected 30", result); end
  endtask

  task automatic test_all_requesting();
    int c;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] av [4] = '{8'hFF, 8'hAA, 8'h0F, 8'hC3};
    logic [W-1:0] bv [4] = '{8'hFF, 8'h55, 8'h3C, 8'hFF};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_bus[i*W +: W] = av[i];
      b_bus[i*W +: W] = bv[i];
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(6, c);
      checks++; if (c < 0) begin errors++; $display("FAIL all_grant_timeout: no grant for op %0d expected one", n); end
      checks++; if (gnt !== (4'b0001 << order[n])) begin errors++; $display("FAIL all_order: op %0d got %b expected %b", n, gnt, 4'b0001 << order[n]); end
      wait_done(W + 2, c);
      if (n == 4) req = 4'b0000;
      checks++; if (done !== (4'b0001 << order[n])) begin errors++; $display("FAIL all_done: op %0d got %b expected %b", n, done, 4'b0001 << order[n]); end
      checks++; if (result !== (av[order[n]] & bv[order[n]])) begin errors++; $display("FAIL all_result: op %0d got %h expected %h", n, result, av[order[n]] & bv[order[n]]); end
    end
    @(negedge clk);
  endtask

  task automatic test_pointer_wrap();
    int c;
    do_reset();
    req = 4'b0100;
    wait_grant(5, c);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_first: got %b expected 0100", gnt); end
    req = 4'b0000;
    wait_done(W + 2, c);
    req = 4'b0011;
    wait_grant(5, c);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_next: got %b expected 0001", gnt); end
    req = 4'b0000;
    wait_done(W + 2, c);
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int c;
    do_reset();
    a_bus[0 +: W] = 8'hA5;
    b_bus[0 +: W] = 8'h3C;
    req = 4'b0001;
    wait_grant(5, c);
    repeat (3) @(negedge clk);
    a_bus[0 +: W] = 8'h00;
    req = 4'b0000;
    wait_done(W + 2, c);
    checks++; if (c !== W - 3) begin errors++; $display("FAIL change_latency: got %0d expected %0d", c, W - 3); end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL change_done: got %b expected 0001", done); end
    checks++; if (result !== 8'h24) begin errors++; $display("FAIL change_result: got %h expected 24", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    int pulses;
    // Runs straight after the operand test: result holds 0x24, pointer is 1.
    a_bus[1*W +: W] = 8'hFF;
    b_bus[1*W +: W] = 8'hFF;
    req = 4'b0010;
    wait_grant(5, c);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result: got %h expected 00", result); end
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done != 4'b0000) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    req = 4'b1001;
    wait_grant(5, c);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_pointer: got %b expected 0001", gnt); end
    req = 4'b0000;
    wait_done(W + 2, c);
    @(negedge clk);
  endtask

  task automatic test_bit_order();
    int c;
    do_reset();
    a_bus[0 +: W] = 8'h01;
    b_bus[0 +: W] = 8'h01;
    req = 4'b0001;
    wait_grant(5, c);
    req = 4'b0000;
    for (int k = 0; k < W; k++) begin
      checks++; if ({a, b} !== ((k == 0) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL bitorder_ab: idx %0d got %b expected %b", k, {a, b}, (k == 0) ? 2'b11 : 2'b00); end
      @(negedge clk);
    end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL bitorder_done: got %b expected 0001", done); end
    checks++; if (result !== 8'h01) begin errors++; $display("FAIL bitorder_result: got %h expected 01", result); end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom());
      a_bus = $urandom();
      b_bus = $urandom();
      @(negedge clk);
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt: cycle %0d got %b expected %b", i, gnt, e_gnt); end
      checks++; if (done !== e_done) begin errors++; $display("FAIL rand_done: cycle %0d got %b expected %b", i, done, e_done); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy: cycle %0d got %b expected %b", i, busy, e_busy); end
      checks++; if (result !== m_res) begin errors++; $display("FAIL rand_result: cycle %0d got %h expected %h", i, result, m_res); end
      checks++; if ({a, b} !== {e_a, e_b}) begin errors++; $display("FAIL rand_ab: cycle %0d got %b expected %b", i, {a, b}, {e_a, e_b}); end
      checks++; if ($countones(gnt) > 1 || $countones(done) > 1) begin errors++; $display("FAIL rand_onehot: cycle %0d got gnt=%b done=%b expected at most one bit", i, gnt, done); end
    end
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_pointer_wrap();
    test_operand_change();
    test_reset_mid();
    test_bit_order();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
